// File: rtl/uart_echo_engine.sv
// Byte echo between UART RX and TX byte interfaces.
// FIFO-buffered, raw or line-at-a-time release.
module uart_echo_engine #(
  parameter int          DATA_BITS = 8,
  parameter int          DEPTH     = 16,
  parameter int unsigned TERM_CHAR = 32'h0D,
  parameter int          CNT_WIDTH = 16,
  localparam int         LVL_W     = $clog2(DEPTH + 1),
  localparam int         PTR_W     = $clog2(DEPTH)
) (
  input  logic                 sysclk,
  input  logic                 rst_in,
  input  logic                 mode_in,
  input  logic                 rx_valid_in,
  input  logic [DATA_BITS-1:0] rx_data_in,
  output logic                 tx_start_out,
  output logic [DATA_BITS-1:0] tx_data_out,
  input  logic                 tx_done_in,
  output logic [LVL_W-1:0]     level_out,
  output logic                 full_out,
  output logic                 empty_out,
  output logic [LVL_W-1:0]     lines_pending_out,
  output logic [CNT_WIDTH-1:0] overflow_cnt_out,
  output logic                 busy_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [DATA_BITS-1:0] TERM =
    DATA_BITS'(TERM_CHAR);
  localparam logic [LVL_W-1:0] LVL_FULL =
    LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX =
    PTR_W'(DEPTH - 1);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [LVL_W-1:0]     lines_q, lines_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
  logic                 flush_q, flush_d;
  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;

  logic                 full;
  logic                 empty;
  logic                 wr_en;
  logic                 drop;
  logic                 eligible;
  logic                 pop;
  logic                 acc_term;
  logic                 pop_term;
  logic [DATA_BITS-1:0] head;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A pop in the same cycle never makes room
  // for the incoming byte: full is registered.
  assign wr_en = rx_valid_in && !full;
  assign drop  = rx_valid_in && full;

  // Line mode waits for a whole line unless the
  // FIFO filled up without one (forced flush).
  assign eligible = !empty &&
    (!mode_in || (lines_q != '0) || flush_q);
  assign pop = (state_q == S_IDLE) && eligible;

  assign acc_term = wr_en && (rx_data_in == TERM);
  assign pop_term = pop && (head == TERM);

  // Storage array; contents need no reset since
  // the pointers and level define validity.
  always_ff @(posedge sysclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= rx_data_in;
    end
  end

  // FIFO pointers, occupancy and counters.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    lines_d  = lines_q;
    ovf_d    = ovf_q;
    flush_d  = flush_q;

    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ?
        '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ?
        '0 : rd_ptr_q + 1'b1;
    end

    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case ({acc_term, pop_term})
      2'b10:   lines_d = lines_q + 1'b1;
      2'b01:   lines_d = lines_q - 1'b1;
      default: lines_d = lines_q;
    endcase

    if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + 1'b1;
    end

    // Flush drains an over-long line and ends
    // once everything stored has been sent.
    if (level_d == '0) begin
      flush_d = 1'b0;
    end else if (mode_in && full &&
                 (lines_q == '0)) begin
      flush_d = 1'b1;
    end
  end

  // Transmit sequencing: pop, start, wait done.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_data_d = head;
          state_d   = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_in) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      lines_q   <= '0;
      ovf_q     <= '0;
      flush_q   <= 1'b0;
      state_q   <= S_IDLE;
      tx_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      lines_q   <= lines_d;
      ovf_q     <= ovf_d;
      flush_q   <= flush_d;
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_start_out      = (state_q == S_START);
  assign tx_data_out       = tx_data_q;
  assign level_out         = level_q;
  assign full_out          = full;
  assign empty_out         = empty;
  assign lines_pending_out = lines_q;
  assign overflow_cnt_out  = ovf_q;
  assign busy_out          = (state_q != S_IDLE);

endmodule
